// File: rtl/jtag_master.sv
// JTAG host driver: runs TAP-reset / IR-scan / DR-scan commands on TCK/TMS/TDI,
// returns the TDO bits captured while shifting and mirrors the target TAP state.
`timescale 1ns/1ps
module jtag_master #(
    parameter int unsigned TCK_HALF = 2,
    parameter int unsigned DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [5:0]        cmd_len,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              tck,
    output logic              tms,
    output logic              tdi,
    input  logic              tdo,
    output logic              trst_n,
    output logic [3:0]        tap_state
);
    localparam int unsigned PH_W  = $clog2(TCK_HALF + 1);
    localparam int unsigned CYC_W = $clog2(DATA_W + 8);
    localparam int unsigned BIT_W = $clog2(DATA_W + 1);

    localparam logic [1:0] OP_RESET = 2'd0;
    localparam logic [1:0] OP_IR    = 2'd1;
    localparam logic [1:0] OP_RSVD  = 2'd3;

    localparam logic [3:0] ST_RESET  = 4'hF, ST_IDLE   = 4'hC, ST_SEL_DR = 4'h7, ST_CAP_DR = 4'h6;
    localparam logic [3:0] ST_SH_DR  = 4'h2, ST_EX1_DR = 4'h1, ST_PAU_DR = 4'h3, ST_EX2_DR = 4'h0;
    localparam logic [3:0] ST_UPD_DR = 4'h5, ST_SEL_IR = 4'h4, ST_CAP_IR = 4'hE, ST_SH_IR  = 4'hA;
    localparam logic [3:0] ST_EX1_IR = 4'h9, ST_PAU_IR = 4'hB, ST_EX2_IR = 4'h8, ST_UPD_IR = 4'hD;

    typedef enum logic [1:0] {M_INIT, M_IDLE, M_RUN, M_RSP} mstate_e;

    function automatic logic [3:0] tap_next(input logic [3:0] s, input logic m);
        case (s)
            ST_RESET:  tap_next = m ? ST_RESET  : ST_IDLE;
            ST_IDLE:   tap_next = m ? ST_SEL_DR : ST_IDLE;
            ST_SEL_DR: tap_next = m ? ST_SEL_IR : ST_CAP_DR;
            ST_CAP_DR: tap_next = m ? ST_EX1_DR : ST_SH_DR;
            ST_SH_DR:  tap_next = m ? ST_EX1_DR : ST_SH_DR;
            ST_EX1_DR: tap_next = m ? ST_UPD_DR : ST_PAU_DR;
            ST_PAU_DR: tap_next = m ? ST_EX2_DR : ST_PAU_DR;
            ST_EX2_DR: tap_next = m ? ST_UPD_DR : ST_SH_DR;
            ST_UPD_DR: tap_next = m ? ST_SEL_DR : ST_IDLE;
            ST_SEL_IR: tap_next = m ? ST_RESET  : ST_CAP_IR;
            ST_CAP_IR: tap_next = m ? ST_EX1_IR : ST_SH_IR;
            ST_SH_IR:  tap_next = m ? ST_EX1_IR : ST_SH_IR;
            ST_EX1_IR: tap_next = m ? ST_UPD_IR : ST_PAU_IR;
            ST_PAU_IR: tap_next = m ? ST_EX2_IR : ST_PAU_IR;
            ST_EX2_IR: tap_next = m ? ST_UPD_IR : ST_SH_IR;
            default:   tap_next = m ? ST_SEL_DR : ST_IDLE;
        endcase
    endfunction

    // {tms, tdi} for TCK cycle c of a command; pre adds the reset->idle step.
    function automatic logic [1:0] seq_bits(input int unsigned c, input logic [1:0] op,
                                            input int unsigned len, input logic [DATA_W-1:0] data,
                                            input logic pre);
        int unsigned hdr, j;
        logic [DATA_W-1:0] sh;
        seq_bits = 2'b00;
        hdr = (op == OP_IR) ? 4 : 3;
        j   = c - 32'(pre);
        sh  = '0;
        if (op == OP_RESET) begin
            seq_bits[1] = (c < 5);
        end else if (c >= 32'(pre)) begin
            if (j < hdr) begin
                seq_bits[1] = (j == 0) || ((op == OP_IR) && (j == 1));
            end else if (j < hdr + len) begin
                sh          = data >> (j - hdr);
                seq_bits[1] = (j == hdr + len - 1);
                seq_bits[0] = sh[0];
            end else begin
                seq_bits[1] = (j == hdr + len);
            end
        end
    endfunction

    function automatic int unsigned n_cycles(input logic [1:0] op, input int unsigned len,
                                             input logic pre);
        if (op == OP_RESET) n_cycles = 6;
        else n_cycles = 32'(pre) + ((op == OP_IR) ? 6 : 5) + len;
    endfunction

    mstate_e            state_q, state_d;
    logic               cmd_ready_q, cmd_ready_d, rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d, data_q, data_d;
    logic               tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d, trst_n_q, trst_n_d, pre_q, pre_d;
    logic [3:0]         tap_q, tap_d;
    logic [PH_W-1:0]    ph_q, ph_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d, n_q, n_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [1:0]         op_q, op_d;
    logic [5:0]         len_q, len_d;
    logic               cmd_legal;

    assign cmd_legal = (cmd_op != OP_RSVD) && (cmd_len != 6'd0) && (32'(cmd_len) <= DATA_W);

    always_comb begin
        state_d = state_q;  cmd_ready_d = cmd_ready_q;  rsp_valid_d = rsp_valid_q;
        rsp_err_d = rsp_err_q;  rsp_data_d = rsp_data_q;  data_d = data_q;
        tck_d = tck_q;  tms_d = tms_q;  tdi_d = tdi_q;  trst_n_d = trst_n_q;  pre_d = pre_q;
        tap_d = tap_q;  ph_d = ph_q;  cyc_d = cyc_q;  n_d = n_q;  bit_d = bit_q;
        op_d = op_q;  len_d = len_q;
        case (state_q)
            M_INIT: begin
                state_d     = M_IDLE;
                cmd_ready_d = 1'b1;
                trst_n_d    = 1'b1;
            end
            M_IDLE: begin
                tms_d = 1'b0;
                tdi_d = 1'b0;
                if (cmd_valid) begin
                    cmd_ready_d = 1'b0;
                    rsp_data_d  = '0;
                    if (!cmd_legal) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        state_d     = M_RSP;
                    end else begin
                        rsp_err_d = 1'b0;
                        op_d      = cmd_op;
                        len_d     = cmd_len;
                        data_d    = cmd_data;
                        pre_d     = (tap_q == ST_RESET);
                        n_d       = CYC_W'(n_cycles(cmd_op, 32'(cmd_len), tap_q == ST_RESET));
                        cyc_d     = '0;
                        ph_d      = '0;
                        bit_d     = '0;
                        {tms_d, tdi_d} = seq_bits(0, cmd_op, 32'(cmd_len), cmd_data,
                                                  tap_q == ST_RESET);
                        state_d   = M_RUN;
                    end
                end
            end
            M_RUN: begin
                if (ph_q == PH_W'(TCK_HALF - 1)) begin
                    ph_d  = '0;
                    tck_d = ~tck_q;
                    if (!tck_q) begin
                        // rising edge: capture TDO while shifting, advance mirror
                        tap_d = tap_next(tap_q, tms_q);
                        if ((tap_q == ST_SH_DR) || (tap_q == ST_SH_IR)) begin
                            rsp_data_d = rsp_data_q | (DATA_W'(tdo) << bit_q);
                            bit_d      = bit_q + BIT_W'(1);
                        end
                    end else if (cyc_q == n_q - CYC_W'(1)) begin
                        rsp_valid_d = 1'b1;
                        tms_d       = 1'b0;
                        tdi_d       = 1'b0;
                        state_d     = M_RSP;
                    end else begin
                        cyc_d = cyc_q + CYC_W'(1);
                        {tms_d, tdi_d} = seq_bits(32'(cyc_q) + 32'd1, op_q, 32'(len_q), data_q, pre_q);
                    end
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            M_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = M_IDLE;
                end
            end
            default: state_d = M_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= M_INIT;  cmd_ready_q <= 1'b0;  rsp_valid_q <= 1'b0;  rsp_err_q <= 1'b0;
            rsp_data_q <= '0;  data_q <= '0;  tck_q <= 1'b0;  tms_q <= 1'b0;  tdi_q <= 1'b0;
            trst_n_q <= 1'b0;  pre_q <= 1'b0;  tap_q <= ST_RESET;  ph_q <= '0;  cyc_q <= '0;
            n_q <= '0;  bit_q <= '0;  op_q <= '0;  len_q <= '0;
        end else begin
            state_q <= state_d;  cmd_ready_q <= cmd_ready_d;  rsp_valid_q <= rsp_valid_d;
            rsp_err_q <= rsp_err_d;  rsp_data_q <= rsp_data_d;  data_q <= data_d;
            tck_q <= tck_d;  tms_q <= tms_d;  tdi_q <= tdi_d;  trst_n_q <= trst_n_d;
            pre_q <= pre_d;  tap_q <= tap_d;  ph_q <= ph_d;  cyc_q <= cyc_d;  n_q <= n_d;
            bit_q <= bit_d;  op_q <= op_d;  len_q <= len_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign tck       = tck_q;
    assign tms       = tms_q;
    assign tdi       = tdi_q;
    assign trst_n    = trst_n_q;
    assign tap_state = tap_q;
endmodule

// File: tb/tb_jtag_master.sv
// Bench for jtag_master: a behavioural 1149.1 target with a variable-length
// loopback chain, directed command table, hand sequences and random commands.
`timescale 1ns/1ps
module tb_jtag_master;
    localparam int TH = 2;
    localparam int DW = 32;

    logic          clk = 1'b0, rst = 1'b1;
    logic          cmd_valid = 1'b0, cmd_ready, rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [1:0]    cmd_op = '0;
    logic [5:0]    cmd_len = '0;
    logic [DW-1:0] cmd_data = '0, rsp_data;
    logic          tck, tms, tdi, trst_n;
    logic          tdo = 1'b0;
    logic [3:0]    tap_state;

    int checks = 0, errors = 0;

    jtag_master #(.TCK_HALF(TH), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_len(cmd_len), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo),
        .trst_n(trst_n), .tap_state(tap_state)
    );

    always #5 clk = ~clk;

    // Target TAP model: controller, capture/shift/update of a chain of chain_len bits.
    int unsigned chain_len = 1;
    logic [31:0] cap_dr = '0, cap_ir = '0, sr = '0, upd_dr = '0, upd_ir = '0;
    logic [3:0]  mst = 4'hF;
    int          shift_cnt = 0;
    logic        tms_log[$];
    logic        tdi_log[$];

    function automatic logic [3:0] tap_step(input logic [3:0] s, input logic m);
        case (s)
            4'hF: return m ? 4'hF : 4'hC;   4'hC: return m ? 4'h7 : 4'hC;
            4'h7: return m ? 4'h4 : 4'h6;   4'h6: return m ? 4'h1 : 4'h2;
            4'h2: return m ? 4'h1 : 4'h2;   4'h1: return m ? 4'h5 : 4'h3;
            4'h3: return m ? 4'h0 : 4'h3;   4'h0: return m ? 4'h5 : 4'h2;
            4'h5: return m ? 4'h7 : 4'hC;   4'h4: return m ? 4'hF : 4'hE;
            4'hE: return m ? 4'h9 : 4'hA;   4'hA: return m ? 4'h9 : 4'hA;
            4'h9: return m ? 4'hD : 4'hB;   4'hB: return m ? 4'h8 : 4'hB;
            4'h8: return m ? 4'hD : 4'hA;   default: return m ? 4'h7 : 4'hC;
        endcase
    endfunction

    always @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            mst <= 4'hF;
        end else begin
            tms_log.push_back(tms);
            tdi_log.push_back(tdi);
            case (mst)
                4'h6: sr <= cap_dr;
                4'hE: sr <= cap_ir;
                4'h2, 4'hA: begin
                    sr        <= (sr >> 1) | (32'(tdi) << (chain_len - 1));
                    shift_cnt <= shift_cnt + 1;
                end
                4'h5: upd_dr <= sr;
                4'hD: upd_ir <= sr;
                default: ;
            endcase
            mst <= tap_step(mst, tms);
        end
    end

    always @(negedge tck) tdo = sr[0];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Issue one command, check response, timing, TMS/TDI stream and target effects.
    task automatic do_cmd(input string nm, input logic [1:0] op, input int len,
                          input logic [31:0] data, input logic [31:0] cap, input int hold,
                          input logic exp_err, input int exp_n, input logic [31:0] exp_rsp);
        int base, sbase, e, k;
        logic [3:0]  pre_st;
        logic [31:0] mask;
        logic [63:0] etms, etdi, atms, atdi;
        mask      = (len >= 32) ? 32'hFFFF_FFFF : ((32'd1 << len) - 32'd1);
        chain_len = (len >= 1 && len <= 32) ? len : 1;
        cap_dr    = cap & mask;
        cap_ir    = cap & mask;
        pre_st    = mst;
        base      = tms_log.size();
        sbase     = shift_cnt;
        e = 0;
        while (!cmd_ready && e < 100) begin @(negedge clk); e++; end
        chk({nm, ":ready"}, 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_len = 6'(len); cmd_data = data;
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        e = 0;
        while (!rsp_valid && e < 2000) begin @(negedge clk); e++; end
        chk({nm, ":latency"}, 64'(e), 64'(2 * TH * exp_n));
        chk({nm, ":rsp"}, {cmd_ready, rsp_err, rsp_data}, {1'b0, exp_err, exp_rsp});
        chk({nm, ":ntck"}, 64'(tms_log.size() - base), 64'(exp_n));
        chk({nm, ":tap"}, 64'(tap_state), 64'(exp_err ? pre_st : 4'hC));
        chk({nm, ":shifts"}, 64'(shift_cnt - sbase), 64'((exp_err || op == 2'd0) ? 0 : len));
        if (!exp_err) begin
            etms = '0; etdi = '0; atms = '0; atdi = '0; k = 0;
            if (op == 2'd0) begin
                etms = 64'b011111;
            end else begin
                if (pre_st == 4'hF) k++;
                etms[k] = 1'b1; k++;
                if (op == 2'd1) begin etms[k] = 1'b1; k++; end
                k += 2;
                for (int i = 0; i < len; i++) begin
                    etdi[k] = data[i];
                    etms[k] = (i == len - 1);
                    k++;
                end
                etms[k] = 1'b1;
            end
            for (int i = 0; i < exp_n && base + i < tms_log.size(); i++) begin
                atms[i] = tms_log[base + i];
                atdi[i] = tdi_log[base + i];
            end
            chk({nm, ":tms_seq"}, atms, etms);
            chk({nm, ":tdi_seq"}, atdi, etdi);
            if (op == 2'd2) chk({nm, ":dr_upd"}, 64'(upd_dr), 64'(data & mask));
            if (op == 2'd1) chk({nm, ":ir_upd"}, 64'(upd_ir), 64'(data & mask));
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk($sformatf("%s:hold%0d", nm, h), {rsp_valid, cmd_ready, rsp_err, rsp_data},
                {1'b1, 1'b0, exp_err, exp_rsp});
        end
        rsp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        rsp_ready = 1'b0;
        chk({nm, ":after_hs"}, {rsp_valid, cmd_ready, tck, tms}, 4'b0100);
    endtask

    typedef struct {
        string       nm;
        logic [1:0]  op;
        int          len;
        logic [31:0] data;
        logic [31:0] cap;
        int          hold;
        logic        exp_err;
        int          exp_n;
        logic [31:0] exp_rsp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int e, sbase, len, n;
        logic [1:0]  op;
        logic [31:0] d, c;
        logic        bad;

        vecs[0] = '{"rst_cmd",   2'd0, 1,  32'h0,         32'h0,         0,  1'b0, 6,  32'h0};
        vecs[1] = '{"dr8",       2'd2, 8,  32'hA5,        32'h3C,        0,  1'b0, 13, 32'h3C};
        vecs[2] = '{"ir4_idle",  2'd1, 4,  32'h9,         32'h5,         1,  1'b0, 10, 32'h5};
        vecs[3] = '{"op3",       2'd3, 8,  32'hFF,        32'h0,         2,  1'b1, 0,  32'h0};
        vecs[4] = '{"len0",      2'd2, 0,  32'h1,         32'h0,         0,  1'b1, 0,  32'h0};
        vecs[5] = '{"len33",     2'd1, 33, 32'h3,         32'h0,         0,  1'b1, 0,  32'h0};
        vecs[6] = '{"dr32_hold", 2'd2, 32, 32'hFFFF_FFFF, 32'h1234_5678, 10, 1'b0, 37, 32'h1234_5678};
        vecs[7] = '{"rst_idle",  2'd0, 5,  32'h0,         32'h0,         0,  1'b0, 6,  32'h0};

        repeat (3) @(negedge clk);
        chk("reset_vals", {cmd_ready, rsp_valid, rsp_err, tck, tms, tdi, trst_n, tap_state, rsp_data},
            {7'b0, 4'hF, 32'h0});
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("reset_release", {trst_n, cmd_ready}, 2'b11);

        foreach (vecs[i])
            do_cmd(vecs[i].nm, vecs[i].op, vecs[i].len, vecs[i].data, vecs[i].cap, vecs[i].hold,
                   vecs[i].exp_err, vecs[i].exp_n, vecs[i].exp_rsp);

        // IR scan straight out of reset needs the extra reset->idle step
        rst = 1'b1; @(posedge clk); @(negedge clk); rst = 1'b0; @(posedge clk); @(negedge clk);
        do_cmd("ir4_from_rst", 2'd1, 4, 32'h9, 32'h1, 0, 1'b0, 11, 32'h1);

        // reset asserted in the middle of a 16-bit DR shift
        chain_len = 16; cap_dr = 32'h0000_BEEF;
        sbase = shift_cnt;
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_len = 6'd16; cmd_data = 32'h0000_1234;
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        e = 0;
        while (shift_cnt - sbase < 5 && e < 2000) begin @(negedge clk); e++; end
        chk("midrst_reached", 64'(shift_cnt - sbase), 64'd5);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("midrst_outputs", {tck, trst_n, tap_state, rsp_valid, cmd_ready, rsp_data},
            {2'b00, 4'hF, 2'b00, 32'h0});
        chk("midrst_target", 64'(mst), 64'hF);
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("midrst_release", {trst_n, cmd_ready}, 2'b11);
        do_cmd("rst_after_abort", 2'd0, 1, 32'h0, 32'h0, 0, 1'b0, 6, 32'h0);

        for (int r = 0; r < 40; r++) begin
            op  = 2'($urandom_range(0, 3));
            bad = (op != 2'd0) && ($urandom_range(0, 5) == 0);
            len = bad ? (($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(33, 63)))
                      : int'($urandom_range(1, 32));
            d   = $urandom;
            c   = $urandom;
            bad = bad || (op == 2'd3);
            if (bad)             n = 0;
            else if (op == 2'd0) n = 6;
            else                 n = len + ((op == 2'd1) ? 6 : 5) + ((mst == 4'hF) ? 1 : 0);
            do_cmd($sformatf("rand%0d", r), op, len, d, c, int'($urandom_range(0, 3)), bad, n,
                   (bad || op == 2'd0) ? 32'h0
                                       : (c & ((len >= 32) ? 32'hFFFF_FFFF : ((32'd1 << len) - 32'd1))));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
